// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock.
// Operands and carry-in are captured on an accepted start; the WIDTH-bit
// sum and final carry are registered at the completion edge and held
// until the next completion.
`timescale 1ns/1ps

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s;
  logic             w_carry_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Single 1-bit full adder: returns {carry_out, sum_bit}
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (y & ci) | (x & ci), x ^ y ^ ci};
  endfunction

  // Current bit slice, next partial result and last-bit detect
  always_comb begin
    {w_carry_next, w_s} = full_add(r_a_sh[0], r_b_sh[0], r_carry);
    w_res_next          = {w_s, r_res[WIDTH-1:1]};
    w_last              = (r_cnt == CNT_W'(WIDTH - 1));
  end

  // Control FSM with datapath shift registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_res   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_carry <= w_carry_next;
          r_res   <= w_res_next;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            sum     <= w_res_next;
            cout    <= w_carry_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases plus
// random operands against an arithmetic reference (a+b+cin).
`timescale 1ns/1ps

module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             cin   = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [8:0]  held    = '0;
  logic [7:0]  ra;
  logic [7:0]  rb;
  logic        rc;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Reference: full-precision sum, bit 8 is the carry-out
  function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
    ref_add = 9'(x) + 9'(y) + 9'(c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands with start at a negedge; return at the negedge after acceptance
  task automatic launch(input logic [7:0] a_i, input logic [7:0] b_i, input logic c_i);
    a     = a_i;
    b     = b_i;
    cin   = c_i;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Follow WIDTH busy cycles, the done cycle and one idle cycle
  task automatic wait_done(input logic [8:0] exp_v, input bit glitch);
    for (int k = 0; k < 8; k++) begin
      chk("busy_shift", 32'(busy), 32'd1);
      chk("done_shift", 32'(done), 32'd0);
      chk("hold_shift", 32'({cout, sum}), 32'(held));
      if (glitch && k == 2) begin
        start = 1'b1;
        a     = 8'($urandom);
        b     = 8'($urandom);
        cin   = 1'($urandom);
      end
      if (glitch && k == 3) start = 1'b0;
      @(negedge clk);
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("result", 32'({cout, sum}), 32'(exp_v));
    held = exp_v;
    @(negedge clk);
    chk("done_drop", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("hold_idle", 32'({cout, sum}), 32'(held));
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    held  = '0;
    @(negedge clk);

    // Directed cases
    launch(8'h5A, 8'h3C, 1'b0);
    wait_done(ref_add(8'h5A, 8'h3C, 1'b0), 1'b0);
    chk("lit_5a_3c", 32'({cout, sum}), 32'h096);
    repeat (3) begin
      @(negedge clk);
      chk("hold_long_idle", 32'({cout, sum}), 32'(held));
    end

    launch(8'hFF, 8'h01, 1'b0);
    wait_done(ref_add(8'hFF, 8'h01, 1'b0), 1'b0);
    chk("lit_ff_01", 32'({cout, sum}), 32'h100);

    launch(8'hFF, 8'hFF, 1'b1);
    wait_done(ref_add(8'hFF, 8'hFF, 1'b1), 1'b0);
    chk("lit_ff_ff_1", 32'({cout, sum}), 32'h1FF);

    // Start pulse and operand changes mid-operation are ignored
    launch(8'h10, 8'h20, 1'b0);
    wait_done(ref_add(8'h10, 8'h20, 1'b0), 1'b1);
    chk("lit_10_20", 32'({cout, sum}), 32'h030);
    chk("no_requeue", 32'(busy), 32'd0);

    // Start held high: back-to-back adds every WIDTH+2 cycles
    a     = 8'h01;
    b     = 8'h01;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      wait_done(9'h002, 1'b0);
      if (i == 2) start = 1'b0;
      @(negedge clk);
    end
    chk("cont_stop", 32'(busy), 32'd0);

    // Asynchronous reset mid-add
    launch(8'($urandom), 8'($urandom), 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_sum",  32'(sum),  32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    held  = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("arst_no_done", 32'(done), 32'd0);
      chk("arst_no_busy", 32'(busy), 32'd0);
    end

    // Random operands with random idle gaps
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      launch(ra, rb, rc);
      wait_done(ref_add(ra, rb, rc), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
